// File: rtl/dump_rd_ctrl_if.sv
// dump_rd_ctrl_if -- request/response bundle between the dump read controller
// and its host-side driver.
//
//   strt_rd   : one-cycle request to begin a dump            (master -> slave)
//   abort     : cancel an active dump                         (master -> slave)
//   ram_addr  : last address written by capture               (master -> slave)
//   resp_sent : current byte has gone out to the host         (master -> slave)
//   rd_addr   : registered RAM read address, all 5 channels   (slave -> master)
//   rd_en     : RAM read strobe                               (slave -> master)
//   dump_vld  : RAM read data valid for sending               (slave -> master)
//   rd_done   : level, every entry has been sent              (slave -> master)
//   busy      : dump in progress                              (slave -> master)
//   timeout   : host stalled pulse                            (slave -> master)
interface dump_rd_ctrl_if #(
    parameter int LOG2 = 9
);
    logic            strt_rd;
    logic            abort;
    logic [LOG2-1:0] ram_addr;
    logic            resp_sent;
    logic [LOG2-1:0] rd_addr;
    logic            rd_en;
    logic            dump_vld;
    logic            rd_done;
    logic            busy;
    logic            timeout;

    modport master (
        output strt_rd, abort, ram_addr, resp_sent,
        input  rd_addr, rd_en, dump_vld, rd_done, busy, timeout
    );

    modport slave (
        input  strt_rd, abort, ram_addr, resp_sent,
        output rd_addr, rd_en, dump_vld, rd_done, busy, timeout
    );
endinterface

// File: rtl/dump_rd_ctrl.sv
// dump_rd_ctrl -- walks the capture RAMs once, oldest entry first, handing
// each byte to the host and waiting for it to be sent before reading the next.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : dump_rd_ctrl_if.slave (strt_rd, abort, ram_addr, resp_sent in;
//         rd_addr, rd_en, dump_vld, rd_done, busy, timeout out)
//
// Optional feature: define DUMP_RD_TIMEOUT_EN to abandon a dump when the host
// leaves a byte unacknowledged for 65535 cycles. Without it, timeout is tied
// low and the controller waits indefinitely.
module dump_rd_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9
) (
    input  logic           clk,
    input  logic           rst,
    dump_rd_ctrl_if.slave  bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ      = 3'd1;
    localparam logic [2:0] LAT       = 3'd2;
    localparam logic [2:0] WAIT_SENT = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    logic [2:0]      r_state;
    logic [LOG2-1:0] r_ptr;
    logic [LOG2-1:0] r_cnt;
    logic            r_rd_done;

    logic            w_start;
    logic [LOG2-1:0] w_start_ptr;
    logic [LOG2-1:0] w_next_ptr;

    // abort outranks a simultaneous start request
    assign w_start     = bus.strt_rd && !bus.abort &&
                         ((r_state == IDLE) || (r_state == DONE));
    // oldest entry sits just past the last written one; depth need not be 2^n
    assign w_start_ptr = (bus.ram_addr == LAST) ? '0 : bus.ram_addr + 1'b1;
    assign w_next_ptr  = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;

`ifdef DUMP_RD_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_timeout;
    assign bus.timeout = r_timeout;
`else
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
`ifdef DUMP_RD_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef DUMP_RD_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state   <= READ;
                        r_rd_done <= 1'b0;
                        r_ptr     <= w_start_ptr;
                        r_cnt     <= '0;
                    end
                end
                READ: begin
                    r_state <= bus.abort ? IDLE : LAT;
                end
                LAT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT_SENT;
`ifdef DUMP_RD_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                WAIT_SENT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (bus.resp_sent) begin
                        if (r_cnt == LAST) begin
                            r_state   <= DONE;
                            r_rd_done <= 1'b1;
                        end else begin
                            r_state <= READ;
                            r_cnt   <= r_cnt + 1'b1;
                            r_ptr   <= w_next_ptr;
                        end
                    end
`ifdef DUMP_RD_TIMEOUT_EN
                    else if (r_to_cnt == 16'hFFFF) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // outputs are decoded from registered state only, so reset clears them at once
    assign bus.rd_addr  = r_ptr;
    assign bus.rd_en    = (r_state == READ);
    assign bus.dump_vld = (r_state == LAT);
    assign bus.rd_done  = r_rd_done;
    assign bus.busy     = (r_state == READ) || (r_state == LAT) ||
                          (r_state == WAIT_SENT);
endmodule

// File: tb/tb_dump_rd_ctrl.sv
module tb_dump_rd_ctrl;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk;
    logic rst;

    dump_rd_ctrl_if #(.LOG2(LOG2)) bus ();

    dump_rd_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];      // expected read addresses, oldest first
    int vld_seen = 0;
    logic prev_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every read strobe consumes one expected address
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
            end else begin
                if (bus.rd_en || prev_en || bus.dump_vld)
                    check("vld_follows_en", int'(bus.dump_vld), int'(prev_en));
                if (bus.rd_en) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rd_en", 1, 0);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        check("rd_addr", int'(bus.rd_addr), e);
                    end
                end
                if (bus.dump_vld) vld_seen++;
                prev_en = bus.rd_en;
            end
        end
    end

    // mode 0: full dump; 1: abort after m-th dump_vld; 2: reset after m-th dump_vld
    // gap < 0 picks a random response delay per byte
    task automatic do_dump(input int a, input int mode, input int m,
                           input int stall, input int gap_fixed);
        int n;
        int t;
        int gap;
        n = (mode == 0) ? ENTRIES : m;
        vld_seen = 0;
        @(posedge clk); #1;
        bus.ram_addr = 9'(a);
        bus.strt_rd  = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back((a + 1 + k) % ENTRIES);
        @(posedge clk); #1;
        bus.strt_rd  = 1'b0;
        bus.ram_addr = 9'($urandom_range(0, ENTRIES - 1));
        @(negedge clk);
        check("rd_en_latency", int'(bus.rd_en), 1);
        check("rd_done_cleared", int'(bus.rd_done), 0);
        for (int k = 0; k < n; k++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.dump_vld && t < 20);
            if (!bus.dump_vld) begin
                check("dump_vld_wait", 0, 1);
                exp_q.delete();
                return;
            end
            if (k == 0) check("vld_latency", t, 1);
            if (k == n - 1 && mode != 0) begin
                repeat (stall) @(posedge clk);
                if (stall > 0) begin
                    @(negedge clk);
                    check("stall_busy", int'(bus.busy), 1);
                    check("stall_timeout", int'(bus.timeout), 0);
                end
                if (mode == 1) begin
                    @(posedge clk); #1 bus.abort = 1'b1;
                    @(posedge clk); #1 bus.abort = 1'b0;
                    @(negedge clk);
                    check("abort_busy", int'(bus.busy), 0);
                    check("abort_rd_done", int'(bus.rd_done), 0);
                end else begin
                    @(posedge clk); #3 rst = 1'b1;
                    #1;
                    check("arst_rd_en", int'(bus.rd_en), 0);
                    check("arst_dump_vld", int'(bus.dump_vld), 0);
                    check("arst_busy", int'(bus.busy), 0);
                    check("arst_rd_done", int'(bus.rd_done), 0);
                    check("arst_timeout", int'(bus.timeout), 0);
                    check("arst_rd_addr", int'(bus.rd_addr), 0);
                    exp_q.delete();
                    @(posedge clk); #2 rst = 1'b0;
                end
                repeat (6) @(negedge clk);
                check("post_stop_busy", int'(bus.busy), 0);
                check("post_stop_queue", exp_q.size(), 0);
                check("post_stop_vld_count", vld_seen, n);
                return;
            end
            gap = (gap_fixed >= 0) ? gap_fixed : $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                // start requests while busy must be ignored
                bus.strt_rd  = ($urandom_range(0, 3) == 0);
                bus.ram_addr = 9'($urandom_range(0, ENTRIES - 1));
            end
            @(posedge clk); #1;
            bus.strt_rd   = 1'b0;
            bus.resp_sent = 1'b1;
            @(posedge clk); #1 bus.resp_sent = 1'b0;
        end
        @(negedge clk);
        check("done_rd_done", int'(bus.rd_done), 1);
        check("done_busy", int'(bus.busy), 0);
        check("done_vld_count", vld_seen, ENTRIES);
        check("done_queue", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.strt_rd   = 1'b0;
        bus.abort     = 1'b0;
        bus.ram_addr  = '0;
        bus.resp_sent = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_dump_vld", int'(bus.dump_vld), 0);
        check("rst_rd_done", int'(bus.rd_done), 0);
        check("rst_rd_addr", int'(bus.rd_addr), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        @(posedge clk); #2 rst = 1'b0;

        // resp_sent in IDLE is ignored
        @(posedge clk); #1 bus.resp_sent = 1'b1;
        @(posedge clk); #1 bus.resp_sent = 1'b0;
        @(negedge clk);
        check("idle_resp_busy", int'(bus.busy), 0);

        // abort beats a simultaneous start
        @(posedge clk); #1;
        bus.ram_addr = 9'd7;
        bus.strt_rd  = 1'b1;
        bus.abort    = 1'b1;
        @(posedge clk); #1;
        bus.strt_rd = 1'b0;
        bus.abort   = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_busy", int'(bus.busy), 0);

        do_dump(100, 0, 0, 0, 2);
        repeat (5) @(negedge clk);
        check("rd_done_hold", int'(bus.rd_done), 1);
        do_dump(383, 0, 0, 0, -1);
        do_dump(0, 0, 0, 0, -1);
        do_dump(50, 1, 11, 0, -1);
        do_dump(50, 0, 0, 0, -1);
        do_dump($urandom_range(0, ENTRIES - 1), 2, $urandom_range(1, 20), 0, -1);
        repeat (4) @(negedge clk);
        check("post_rst_idle", int'(bus.busy), 0);
        do_dump($urandom_range(0, ENTRIES - 1), 1, 3, 300, -1);
        for (int i = 0; i < 3; i++)
            do_dump($urandom_range(0, ENTRIES - 1), 1, $urandom_range(1, 30), 0, -1);
        do_dump($urandom_range(0, ENTRIES - 1), 0, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
